// File: rtl/ex_flag_stage_pkg.sv
// ex_flag_stage_pkg
//   Shared definitions for the execute/flag pipeline stage:
//   - opcode constants (ADD..HLT)
//   - flag-update class encoding and an opcode -> class lookup
//   - stage state encodings (RUN / DRAIN / HALTED)
package ex_flag_stage_pkg;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_RED    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;
  localparam logic [3:0] OP_HLT    = 4'b1111;

  // Which flags an accepted instruction is allowed to write.
  typedef enum logic [1:0] {
    FC_ALL    = 2'd0,   // Z, V and N
    FC_Z_ONLY = 2'd1,   // Z only
    FC_NONE   = 2'd2    // flags untouched
  } flag_class_e;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  function automatic flag_class_e flag_class(input logic [3:0] op);
    flag_class_e fc;
    case (op)
      OP_ADD, OP_SUB:                 fc = FC_ALL;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: fc = FC_Z_ONLY;
      default:                        fc = FC_NONE;  // RED, PADDSB, HLT, others
    endcase
    return fc;
  endfunction

endpackage

// File: rtl/ex_flag_stage_flag_reg.sv
// ex_flag_stage_flag_reg
//   Architectural Z/V/N flag register with per-bit write enables and the
//   zero / negative detect on the (already saturated) ALU result.
// Ports:
//   clk, rst            clock, asynchronous active-high reset (flags -> 0)
//   result [DW-1:0]     value the Z/N detect looks at
//   ovfl                value written into V
//   en_z, en_v, en_n    per-flag write enables
//   flag_z/v/n          registered flags
module ex_flag_stage_flag_reg #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] result,
  input  logic          ovfl,
  input  logic          en_z,
  input  logic          en_v,
  input  logic          en_n,
  output logic          flag_z,
  output logic          flag_v,
  output logic          flag_n
);

  logic is_zero;
  logic is_neg;

  assign is_zero = (result == '0);
  assign is_neg  = result[DW-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_z <= 1'b0;
      flag_v <= 1'b0;
      flag_n <= 1'b0;
    end else begin
      if (en_z) flag_z <= is_zero;
      if (en_v) flag_v <= ovfl;
      if (en_n) flag_n <= is_neg;
    end
  end

endmodule

// File: rtl/ex_flag_stage.sv
// ex_flag_stage
//   Pipeline stage after the ALU: registers result/destination/write-enable,
//   maintains the Z/V/N flags and sequences halt (RUN -> DRAIN -> HALTED).
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   in_valid, stall, flush       upstream valid, hold request, squash request
//   opcode, alu_result, alu_ovfl ALU instruction info and outputs
//   dst_reg, wr_en               destination and register-file write request
//   out_valid, out_result,
//   out_dst, out_wr_en           registered stage outputs to mem/writeback
//   flag_z, flag_v, flag_n       architectural flags (registered, not forwarded)
//   halted                       processor halted (left only by reset)
module ex_flag_stage
  import ex_flag_stage_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          stall,
  input  logic          flush,
  input  logic [3:0]    opcode,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_ovfl,
  input  logic [RW-1:0] dst_reg,
  input  logic          wr_en,
  output logic          out_valid,
  output logic [DW-1:0] out_result,
  output logic [RW-1:0] out_dst,
  output logic          out_wr_en,
  output logic          flag_z,
  output logic          flag_v,
  output logic          flag_n,
  output logic          halted
);

  logic [1:0]  state_reg;
  logic        accept;
  logic        is_hlt;
  flag_class_e fc;

  assign accept = in_valid & ~stall & ~flush & (state_reg == ST_RUN);
  assign is_hlt = (opcode == OP_HLT);
  assign fc     = flag_class(opcode);
  assign halted = (state_reg == ST_HALTED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_RUN;
      out_valid  <= 1'b0;
      out_wr_en  <= 1'b0;
      out_result <= '0;
      out_dst    <= '0;
    end else if (state_reg == ST_HALTED) begin
      // Only reset leaves HALTED; flush and stall are ignored here.
      out_valid <= 1'b0;
      out_wr_en <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_wr_en <= 1'b0;
      state_reg <= ST_RUN;   // also squashes a draining HLT
    end else if (!stall) begin
      out_valid  <= accept;
      // HLT is visible downstream but never writes the register file.
      out_wr_en  <= accept & wr_en & ~is_hlt;
      out_result <= alu_result;
      out_dst    <= dst_reg;
      if (state_reg == ST_DRAIN)
        state_reg <= ST_HALTED;
      else if (accept && is_hlt)
        state_reg <= ST_DRAIN;
    end
  end

  ex_flag_stage_flag_reg #(.DW(DW)) u_flag_reg (
    .clk    (clk),
    .rst    (rst),
    .result (alu_result),
    .ovfl   (alu_ovfl),
    .en_z   (accept & (fc != FC_NONE)),
    .en_v   (accept & (fc == FC_ALL)),
    .en_n   (accept & (fc == FC_ALL)),
    .flag_z (flag_z),
    .flag_v (flag_v),
    .flag_n (flag_n)
  );

endmodule

// File: tb/tb_ex_flag_stage.sv
// tb_ex_flag_stage
//   Directed bench for ex_flag_stage: reset, flag update classes, saturated
//   ADD, stall/flush priority, halt drain and reset out of HALTED.
module tb_ex_flag_stage;
  import ex_flag_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, stall, flush;
  logic [3:0]  opcode;
  logic [15:0] alu_result;
  logic        alu_ovfl;
  logic [3:0]  dst_reg;
  logic        wr_en;
  logic        out_valid;
  logic [15:0] out_result;
  logic [3:0]  out_dst;
  logic        out_wr_en;
  logic        flag_z, flag_v, flag_n, halted;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_flag_stage #(.DW(16), .RW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .stall      (stall),
    .flush      (flush),
    .opcode     (opcode),
    .alu_result (alu_result),
    .alu_ovfl   (alu_ovfl),
    .dst_reg    (dst_reg),
    .wr_en      (wr_en),
    .out_valid  (out_valid),
    .out_result (out_result),
    .out_dst    (out_dst),
    .out_wr_en  (out_wr_en),
    .flag_z     (flag_z),
    .flag_v     (flag_v),
    .flag_n     (flag_n),
    .halted     (halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check the control outputs and flags in one go: {valid, wr_en, halted, z, v, n}.
  task automatic chk_ctl(input string tag, input logic [5:0] exp);
    chk(tag, 32'({out_valid, out_wr_en, halted, flag_z, flag_v, flag_n}), 32'(exp));
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] res,
                       input logic ov, input logic [3:0] dst, input logic we);
    in_valid   = v;
    opcode     = op;
    alu_result = res;
    alu_ovfl   = ov;
    dst_reg    = dst;
    wr_en      = we;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b0, OP_ADD, 16'h0000, 1'b0, 4'h0, 1'b0);
    tick;
    $display("reset: valid=%b halted=%b zvn=%b%b%b", out_valid, halted, flag_z, flag_v, flag_n);
    chk_ctl("reset_ctl", 6'b000_000);
    chk("reset_result", 32'(out_result), 32'h0);
    rst = 1'b0;

    // Saturated ADD 0x7FFF + 1
    drive(1'b1, OP_ADD, 16'h7FFF, 1'b1, 4'h3, 1'b1); tick;
    $display("ADD sat: res=%h dst=%h zvn=%b%b%b", out_result, out_dst, flag_z, flag_v, flag_n);
    chk_ctl("add_sat_ctl", 6'b110_010);
    chk("add_sat_result", 32'(out_result), 32'h7FFF);
    chk("add_sat_dst", 32'(out_dst), 32'h3);

    // SUB 5-5 = 0
    drive(1'b1, OP_SUB, 16'h0000, 1'b0, 4'h4, 1'b1); tick;
    $display("SUB zero: zvn=%b%b%b", flag_z, flag_v, flag_n);
    chk_ctl("sub_zero_ctl", 6'b110_100);
    chk("sub_zero_dst", 32'(out_dst), 32'h4);

    // XOR 0x8000: Z only, N stays 0
    drive(1'b1, OP_XOR, 16'h8000, 1'b1, 4'h5, 1'b1); tick;
    $display("XOR 8000: res=%h zvn=%b%b%b", out_result, flag_z, flag_v, flag_n);
    chk_ctl("xor_8000_ctl", 6'b110_000);
    chk("xor_8000_result", 32'(out_result), 32'h8000);

    // ADD 0x8000 sets N, then XOR 0 sets Z but must keep N
    drive(1'b1, OP_ADD, 16'h8000, 1'b0, 4'h1, 1'b1); tick;
    $display("ADD 8000: zvn=%b%b%b", flag_z, flag_v, flag_n);
    chk_ctl("add_neg_ctl", 6'b110_001);
    drive(1'b1, OP_XOR, 16'h0000, 1'b1, 4'h1, 1'b1); tick;
    $display("XOR 0: zvn=%b%b%b", flag_z, flag_v, flag_n);
    chk_ctl("xor_zero_ctl", 6'b110_101);
    drive(1'b1, OP_SLL, 16'h0001, 1'b1, 4'h2, 1'b1); tick;
    $display("SLL 1: zvn=%b%b%b", flag_z, flag_v, flag_n);
    chk_ctl("sll_ctl", 6'b110_001);

    // RED and PADDSB with zero result leave flags alone; PADDSB without write
    drive(1'b1, OP_RED, 16'h0000, 1'b1, 4'h6, 1'b1); tick;
    $display("RED 0: zvn=%b%b%b", flag_z, flag_v, flag_n);
    chk_ctl("red_ctl", 6'b110_001);
    drive(1'b1, OP_PADDSB, 16'h0000, 1'b1, 4'h8, 1'b0); tick;
    $display("PADDSB 0: we=%b zvn=%b%b%b", out_wr_en, flag_z, flag_v, flag_n);
    chk_ctl("paddsb_ctl", 6'b100_001);

    // Stall three cycles with ADD 0 waiting
    stall = 1'b1;
    drive(1'b1, OP_ADD, 16'h0000, 1'b1, 4'h7, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick;
      $display("stall %0d: valid=%b dst=%h zvn=%b%b%b", i, out_valid, out_dst, flag_z, flag_v, flag_n);
      chk_ctl("stall_ctl", 6'b100_001);
      chk("stall_dst", 32'(out_dst), 32'h8);
    end
    stall = 1'b0; tick;
    $display("stall release: dst=%h zvn=%b%b%b", out_dst, flag_z, flag_v, flag_n);
    chk_ctl("stall_rel_ctl", 6'b110_110);
    chk("stall_rel_dst", 32'(out_dst), 32'h7);

    // flush + stall with a valid ADD
    flush = 1'b1; stall = 1'b1;
    drive(1'b1, OP_ADD, 16'h8000, 1'b0, 4'h9, 1'b1); tick;
    $display("flush+stall: valid=%b we=%b zvn=%b%b%b", out_valid, out_wr_en, flag_z, flag_v, flag_n);
    chk_ctl("flush_stall_ctl", 6'b000_110);
    flush = 1'b0; stall = 1'b0;

    // ADD 0x8000 ovfl (V=1,N=1), then flush alone with an ADD 0
    drive(1'b1, OP_ADD, 16'h8000, 1'b1, 4'h2, 1'b1); tick;
    $display("ADD 8000 ov: zvn=%b%b%b", flag_z, flag_v, flag_n);
    chk_ctl("add_vn_ctl", 6'b110_011);
    flush = 1'b1;
    drive(1'b1, OP_ADD, 16'h0000, 1'b0, 4'h2, 1'b1); tick;
    $display("flush: valid=%b zvn=%b%b%b", out_valid, flag_z, flag_v, flag_n);
    chk_ctl("flush_ctl", 6'b000_011);
    flush = 1'b0;

    // HLT, two stalled DRAIN cycles, then release
    drive(1'b1, OP_HLT, 16'h0000, 1'b0, 4'hA, 1'b1); tick;
    $display("HLT: valid=%b we=%b halted=%b", out_valid, out_wr_en, halted);
    chk_ctl("hlt_ctl", 6'b100_011);
    stall = 1'b1;
    drive(1'b1, OP_ADD, 16'h0000, 1'b0, 4'hB, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick;
      $display("drain stall %0d: valid=%b halted=%b", i, out_valid, halted);
      chk_ctl("drain_stall_ctl", 6'b100_011);
    end
    stall = 1'b0; tick;
    $display("drain release: valid=%b halted=%b zvn=%b%b%b", out_valid, halted, flag_z, flag_v, flag_n);
    chk_ctl("halt_enter_ctl", 6'b001_011);
    tick;
    $display("halted ADD: valid=%b halted=%b zvn=%b%b%b", out_valid, halted, flag_z, flag_v, flag_n);
    chk_ctl("halted_add_ctl", 6'b001_011);
    flush = 1'b1; tick;
    $display("halted flush: valid=%b halted=%b", out_valid, halted);
    chk_ctl("halted_flush_ctl", 6'b001_011);
    flush = 1'b0;

    // Asynchronous reset from HALTED with flags set
    #2 rst = 1'b1;
    #1;
    $display("async rst: valid=%b halted=%b zvn=%b%b%b", out_valid, halted, flag_z, flag_v, flag_n);
    chk_ctl("async_rst_ctl", 6'b000_000);
    tick;
    chk_ctl("rst_hold_ctl", 6'b000_000);
    @(negedge clk) rst = 1'b0;
    drive(1'b1, OP_ADD, 16'h0000, 1'b0, 4'h6, 1'b1); tick;
    $display("post rst ADD: valid=%b dst=%h zvn=%b%b%b", out_valid, out_dst, flag_z, flag_v, flag_n);
    chk_ctl("post_rst_ctl", 6'b110_100);
    chk("post_rst_dst", 32'(out_dst), 32'h6);

    // HLT followed by flush during DRAIN returns to RUN
    drive(1'b1, OP_HLT, 16'h0000, 1'b0, 4'h1, 1'b0); tick;
    chk_ctl("hlt2_ctl", 6'b100_100);
    flush = 1'b1;
    drive(1'b0, OP_ADD, 16'h0000, 1'b0, 4'h1, 1'b0); tick;
    $display("drain flush: valid=%b halted=%b", out_valid, halted);
    chk_ctl("drain_flush_ctl", 6'b000_100);
    flush = 1'b0;
    drive(1'b1, OP_ADD, 16'h8000, 1'b0, 4'hC, 1'b1); tick;
    $display("run again: valid=%b halted=%b zvn=%b%b%b", out_valid, halted, flag_z, flag_v, flag_n);
    chk_ctl("run_again_ctl", 6'b110_001);
    tick;
    $display("after run again: valid=%b halted=%b", out_valid, halted);
    chk_ctl("still_run_ctl", 6'b110_001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
